// File: rtl/text_overlay_engine_if.sv
// Character-buffer write port of the text overlay: writes, bulk clear and busy status.
interface text_overlay_engine_if #(
   parameter int unsigned AW = 6
) ();
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [6:0]    wr_char;
   logic          wr_blink;
   logic          clear;
   logic          busy;

   modport master (output wr_en, wr_addr, wr_char, wr_blink, clear, input busy);
   modport slave  (input wr_en, wr_addr, wr_char, wr_blink, clear, output busy);
endinterface

// File: rtl/text_overlay_engine.sv
// Writable COLS x ROWS character overlay rendered as scaled 8x8 glyphs with per-cell blink.
// Two-stage pixel pipeline: cell/glyph coordinates, then buffer read and font lookup.
module text_overlay_engine #(
   parameter int unsigned COLS         = 16,
   parameter int unsigned ROWS         = 4,
   parameter int unsigned SCALE        = 2,
   parameter int unsigned ORIGIN_X     = 160,
   parameter int unsigned ORIGIN_Y     = 200,
   parameter int unsigned STRIDE_X     = 20,
   parameter int unsigned STRIDE_Y     = 20,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [9:0]                 i_x,
   input  logic [9:0]                 i_y,
   input  logic                       i_frame_start,
   text_overlay_engine_if.slave       io_bus,
   output logic                       o_pixel_on
);
   localparam int unsigned N  = COLS * ROWS;
   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [10:0] X_LO = 11'(ORIGIN_X);
   localparam logic [10:0] X_HI = 11'(ORIGIN_X + COLS * STRIDE_X);
   localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
   localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + ROWS * STRIDE_Y);
   localparam logic [9:0]  SX   = 10'(STRIDE_X);
   localparam logic [9:0]  SY   = 10'(STRIDE_Y);
   localparam logic [9:0]  SC   = 10'(SCALE);
   localparam logic [9:0]  GW   = 10'(8 * SCALE);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]    r_state;
   logic [AW-1:0] r_clr_addr;
   logic [7:0]    r_mem [N];
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;
   logic          r_in_region;
   logic          r_gap;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [2:0]    r_bit;
   logic [2:0]    r_line;
   logic          r_pixel_on;

   logic          w_in_region;
   logic [9:0]    w_rel_x;
   logic [9:0]    w_rel_y;
   logic [9:0]    w_mod_x;
   logic [9:0]    w_mod_y;
   logic          w_wr_ok;
   logic [AW-1:0] w_rd_idx;
   logic [7:0]    w_cell;
   logic [63:0]   w_glyph;
   logic [7:0]    w_font_row;

   // Top row in bits [63:56], MSB of each row is the leftmost pixel.
   function automatic logic [63:0] glyph(input logic [6:0] c);
      case (c)
         7'h41: glyph = 64'h183C66667E666600;
         7'h42: glyph = 64'h7C66667C66667C00;
         7'h43: glyph = 64'h3C66606060663C00;
         7'h44: glyph = 64'h786C6666666C7800;
         7'h45: glyph = 64'h7E60607860607E00;
         7'h46: glyph = 64'h7E60607860606000;
         7'h47: glyph = 64'h3C66606E66663C00;
         7'h48: glyph = 64'hC3C3C3FFC3C3C300;
         7'h49: glyph = 64'h3C18181818183C00;
         7'h4A: glyph = 64'h1E0C0C0C0C6C3800;
         7'h4B: glyph = 64'h666C7870786C6600;
         7'h4C: glyph = 64'h6060606060607E00;
         7'h4D: glyph = 64'hC3E7FFDBC3C3C300;
         7'h4E: glyph = 64'h66767E7E6E666600;
         7'h4F: glyph = 64'h3C66666666663C00;
         7'h50: glyph = 64'h7C66667C60606000;
         7'h51: glyph = 64'h3C666666663C0E00;
         7'h52: glyph = 64'h7C66667C786C6600;
         7'h53: glyph = 64'h3C66603C06663C00;
         7'h54: glyph = 64'hFF18181818181800;
         7'h55: glyph = 64'h6666666666663C00;
         7'h56: glyph = 64'h66666666663C1800;
         7'h57: glyph = 64'hC3C3C3DBFFE7C300;
         7'h58: glyph = 64'h66663C183C666600;
         7'h59: glyph = 64'h6666663C18181800;
         7'h5A: glyph = 64'h7E060C1830607E00;
         7'h30: glyph = 64'h3C666E7666663C00;
         7'h31: glyph = 64'h1838181818187E00;
         7'h32: glyph = 64'h3C66060C30607E00;
         7'h33: glyph = 64'h3C66061C06663C00;
         7'h34: glyph = 64'h060E1E667F060600;
         7'h35: glyph = 64'h7E607C0606663C00;
         7'h36: glyph = 64'h3C66607C66663C00;
         7'h37: glyph = 64'h7E660C1818181800;
         7'h38: glyph = 64'h3C66663C66663C00;
         7'h39: glyph = 64'h3C66663E06663C00;
         default: glyph = 64'h0;
      endcase
   endfunction

   assign io_bus.busy = (r_state == ST_CLEAR);
   assign w_wr_ok     = io_bus.wr_en && (32'(io_bus.wr_addr) < N);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
         if (r_clr_addr == AW'(N - 1)) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
         end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
         end
      end else if (io_bus.clear) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end
   end

   // Clear has priority over a same-cycle write; writes are ignored while clearing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= 8'h20;
         end else if (!io_bus.clear && w_wr_ok) begin
            r_mem[io_bus.wr_addr] <= {io_bus.wr_blink, io_bus.wr_char};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (i_frame_start) begin
         if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_in_region = ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI) &&
                    ({1'b0, i_y} >= Y_LO) && ({1'b0, i_y} < Y_HI);
      w_rel_x     = w_in_region ? (i_x - X_LO[9:0]) : '0;
      w_rel_y     = w_in_region ? (i_y - Y_LO[9:0]) : '0;
      w_mod_x     = w_rel_x % SX;
      w_mod_y     = w_rel_y % SY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_region <= 1'b0;
         r_gap       <= 1'b0;
         r_col       <= '0;
         r_row       <= '0;
         r_bit       <= '0;
         r_line      <= '0;
      end else begin
         r_in_region <= w_in_region;
         r_gap       <= (w_mod_x >= GW) || (w_mod_y >= GW);
         r_col       <= CW'(w_rel_x / SX);
         r_row       <= RW'(w_rel_y / SY);
         r_bit       <= 3'(w_mod_x / SC);
         r_line      <= 3'(w_mod_y / SC);
      end
   end

   // ~r_line / ~r_bit select row 7-line counted from the LSB end and pixel 7-bit.
   always_comb begin
      w_rd_idx   = AW'(r_row * COLS + r_col);
      w_cell     = r_mem[w_rd_idx];
      w_glyph    = glyph(w_cell[6:0]);
      w_font_row = w_glyph[{~r_line, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pixel_on <= 1'b0;
      end else begin
         r_pixel_on <= r_in_region & ~r_gap & ~(w_cell[7] & r_blink_phase) & w_font_row[~r_bit];
      end
   end

   assign o_pixel_on = r_pixel_on;
endmodule

// File: tb/tb_text_overlay_engine.sv
// Directed bench for text_overlay_engine: clear timing, glyph rendering, blink, collisions.
// A second small instance exercises dropped out-of-range writes.
module tb_text_overlay_engine;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       frame_start = 1'b0;
   logic       pixel_on;
   logic       pixel_on2;
   int         n_vec = 0;
   int         n_err = 0;

   text_overlay_engine_if #(.AW(6)) bus ();
   text_overlay_engine_if #(.AW(3)) bus2 ();

   text_overlay_engine dut (
      .clk           (clk),
      .rst           (rst),
      .i_x           (x),
      .i_y           (y),
      .i_frame_start (frame_start),
      .io_bus        (bus),
      .o_pixel_on    (pixel_on)
   );

   text_overlay_engine #(.COLS(3), .ROWS(2)) dut2 (
      .clk           (clk),
      .rst           (rst),
      .i_x           (x),
      .i_y           (y),
      .i_frame_start (frame_start),
      .io_bus        (bus2),
      .o_pixel_on    (pixel_on2)
   );

   always #5 clk = ~clk;

   task automatic write_cell(input bit sel, input int addr, input logic [6:0] ch, input bit bl);
      @(negedge clk);
      if (sel) begin
         bus2.wr_en = 1'b1; bus2.wr_addr = 3'(addr); bus2.wr_char = ch; bus2.wr_blink = bl;
      end else begin
         bus.wr_en = 1'b1; bus.wr_addr = 6'(addr); bus.wr_char = ch; bus.wr_blink = bl;
      end
      @(negedge clk);
      bus.wr_en  = 1'b0;
      bus2.wr_en = 1'b0;
   endtask

   task automatic sample(input int px, input int py, output logic p1, output logic p2);
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      @(negedge clk);
      @(negedge clk);
      p1 = pixel_on;
      p2 = pixel_on2;
   endtask

   task automatic pulse_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
      end
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int cnt;
      int errs;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b1 || pixel_on !== 1'b0) begin
         $display("FAIL reset_state: busy=%b pixel_on=%b, want busy=1 pixel_on=0", bus.busy, pixel_on);
         n_err++;
      end
      count_busy(cnt);
      n_vec++;
      if (cnt !== 64) begin
         $display("FAIL reset_busy_len: got %0d cycles, want 64", cnt);
         n_err++;
      end
      errs = 0;
      for (int j = 0; j < 320 * 80 + 2; j++) begin
         @(negedge clk);
         if (j >= 2 && pixel_on !== 1'b0) errs++;
         if (j < 320 * 80) begin
            x = 10'(160 + j % 320);
            y = 10'(200 + j / 320);
         end
      end
      n_vec++;
      if (errs != 0) begin
         $display("FAIL blank_scan: %0d lit pixels, want 0", errs);
         n_err++;
      end
   endtask

   task automatic test_glyph;
      logic p, q;
      int   px [6] = '{160, 164, 176, 159, 160, 166};
      int   py [6] = '{200, 200, 200, 200, 206, 200};
      logic ex [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      write_cell(0, 0, 7'h48, 1'b0);
      for (int i = 0; i < 6; i++) begin
         sample(px[i], py[i], p, q);
         n_vec++;
         if (p !== ex[i]) begin
            $display("FAIL glyph_H(%0d,%0d): got %b want %b", px[i], py[i], p, ex[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_region_scan;
      write_cell(0, 17, 7'h54, 1'b0);
      for (int j = 0; j < 22; j++) begin
         @(negedge clk);
         if (j >= 2) begin
            n_vec++;
            if (pixel_on !== ((178 + j) < 196)) begin
               $display("FAIL scan_T x=%0d: got %b want %b", 178 + j, pixel_on, (178 + j) < 196);
               n_err++;
            end
         end
         if (j < 20) begin
            x = 10'(180 + j);
            y = 10'd220;
         end
      end
   endtask

   task automatic test_blink;
      logic p, q;
      int   pulses [4] = '{0, 29, 1, 30};
      logic ex     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      write_cell(0, 0, 7'h41, 1'b1);
      for (int i = 0; i < 4; i++) begin
         pulse_frames(pulses[i]);
         sample(166, 200, p, q);
         n_vec++;
         if (p !== ex[i]) begin
            $display("FAIL blink_step%0d: got %b want %b", i, p, ex[i]);
            n_err++;
         end
         if (i == 2) begin
            sample(180, 220, p, q);
            n_vec++;
            if (p !== 1'b1) begin
               $display("FAIL blink_nonblink_cell: got %b want 1", p);
               n_err++;
            end
         end
      end
   endtask

   task automatic test_clear;
      int   cnt;
      logic p, q;
      @(negedge clk);
      bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 6'd1; bus.wr_char = 7'h48;
      @(negedge clk);
      bus.clear = 1'b0; bus.wr_en = 1'b0;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 200) begin
         cnt++;
         bus.wr_en = (cnt == 5);
         bus.wr_addr = 6'd2;
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      n_vec++;
      if (cnt !== 64) begin
         $display("FAIL clear_busy_len: got %0d cycles, want 64", cnt);
         n_err++;
      end
      sample(180, 200, p, q);
      n_vec++;
      if (p !== 1'b0) begin
         $display("FAIL clear_beats_write: got %b want 0", p);
         n_err++;
      end
      sample(200, 200, p, q);
      n_vec++;
      if (p !== 1'b0) begin
         $display("FAIL write_during_busy: got %b want 0", p);
         n_err++;
      end
      sample(166, 200, p, q);
      n_vec++;
      if (p !== 1'b0) begin
         $display("FAIL clear_erases: got %b want 0", p);
         n_err++;
      end
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      repeat (10) @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         $display("FAIL clear_cycle10_busy: got %b want 1", bus.busy);
         n_err++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(cnt);
      n_vec++;
      if (cnt !== 64) begin
         $display("FAIL rst_restart_len: got %0d cycles, want 64", cnt);
         n_err++;
      end
   endtask

   task automatic test_rw_collision;
      write_cell(0, 0, 7'h41, 1'b0);
      @(negedge clk);
      x = 10'd160; y = 10'd200;
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_char = 7'h4D; bus.wr_blink = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b0;
      n_vec++;
      if (pixel_on !== 1'b0) begin
         $display("FAIL collide_old: got %b want 0", pixel_on);
         n_err++;
      end
      @(negedge clk);
      n_vec++;
      if (pixel_on !== 1'b1) begin
         $display("FAIL collide_new: got %b want 1", pixel_on);
         n_err++;
      end
   endtask

   task automatic test_out_of_range;
      logic p, q;
      write_cell(1, 6, 7'h48, 1'b0);
      write_cell(1, 7, 7'h48, 1'b0);
      for (int c = 0; c < 6; c++) begin
         sample(160 + 20 * (c % 3), 200 + 20 * (c / 3), p, q);
         n_vec++;
         if (q !== 1'b0) begin
            $display("FAIL oor_cell%0d: got %b want 0", c, q);
            n_err++;
         end
      end
      write_cell(1, 5, 7'h48, 1'b0);
      sample(200, 220, p, q);
      n_vec++;
      if (q !== 1'b1) begin
         $display("FAIL inrange_last_cell: got %b want 1", q);
         n_err++;
      end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_char = '0; bus.wr_blink = 1'b0; bus.clear = 1'b0;
      bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_char = '0; bus2.wr_blink = 1'b0;
      bus2.clear = 1'b0;
      test_reset();
      test_glyph();
      test_region_scan();
      test_blink();
      test_clear();
      test_rw_collision();
      test_out_of_range();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
